// File: rtl/rf_wb_pkg.sv
// Write-back queue shared definitions.
// Purpose: widths, default depth and the stored entry layout used by the
// write-back queue, its lookup matcher and its interface.
// Ports: none (package).
package rf_wb_pkg;

  localparam int REG_W         = 3;
  localparam int DATA_W        = 16;
  localparam int DEFAULT_DEPTH = 4;
  localparam int COUNT_W       = 4;

  // One pending register-file write: destination index plus data.
  typedef struct packed {
    logic [REG_W-1:0]  regSel;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/rf_wb_queue_if.sv
// Write-back queue bundle.
// Purpose: groups the request handshake, register-file write port, lookup
// ports and status outputs of the write-back queue.
// Ports (slave view, i.e. the queue itself):
//   in : req_valid, req_reg, req_data, drain_en, lookup1sel, lookup2sel
//   out: req_ready, rf_write, rf_writeregsel, rf_writedata,
//        hit1, hit1data, hit2, hit2data, count, err
// The master view is the mirror image and belongs to the writeback source /
// register-file side.
interface rf_wb_queue_if;
  import rf_wb_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [REG_W-1:0]   req_reg;
  logic [DATA_W-1:0]  req_data;
  logic               drain_en;
  logic               rf_write;
  logic [REG_W-1:0]   rf_writeregsel;
  logic [DATA_W-1:0]  rf_writedata;
  logic [REG_W-1:0]   lookup1sel;
  logic [REG_W-1:0]   lookup2sel;
  logic               hit1;
  logic               hit2;
  logic [DATA_W-1:0]  hit1data;
  logic [DATA_W-1:0]  hit2data;
  logic [COUNT_W-1:0] count;
  logic               err;

  modport slave (
    input  req_valid, req_reg, req_data, drain_en, lookup1sel, lookup2sel,
    output req_ready, rf_write, rf_writeregsel, rf_writedata,
           hit1, hit1data, hit2, hit2data, count, err
  );

  modport master (
    output req_valid, req_reg, req_data, drain_en, lookup1sel, lookup2sel,
    input  req_ready, rf_write, rf_writeregsel, rf_writedata,
           hit1, hit1data, hit2, hit2data, count, err
  );

endinterface

// File: rtl/rf_wb_match.sv
// Youngest-match lookup over the pending write entries.
// Purpose: given the entry storage, per-entry valid bits and the head
// pointer, report whether any valid entry targets sel_i and return the data
// of the youngest such entry (the one closest to the tail).
// Ports:
//   entries_i : all stored entries, indexed by storage slot
//   valid_i   : per-slot occupied flags
//   head_i    : slot of the oldest entry
//   sel_i     : register index being looked up
//   hit_o     : a matching valid entry exists
//   data_o    : data of the youngest match, zero when there is none
module rf_wb_match
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  entry_t [DEPTH-1:0] entries_i,
  input  logic   [DEPTH-1:0] valid_i,
  input  logic   [PTR_W-1:0] head_i,
  input  logic   [REG_W-1:0] sel_i,
  output logic               hit_o,
  output logic  [DATA_W-1:0] data_o
);

  logic [PTR_W-1:0] slot;

  // Walk the slots in age order starting at the head so that a later
  // (younger) match simply overwrites an earlier one; the last writer in
  // the loop is therefore the entry nearest the tail.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    slot   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_i + PTR_W'(i);
      if (valid_i[slot] && (entries_i[slot].regSel == sel_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[slot].data;
      end
    end
  end

endmodule

// File: rtl/rf_wb_queue.sv
// Register-file write-back queue.
// Purpose: buffers write requests from the writeback source in order and
// drains them into the register-file write port whenever that port is
// free, while letting two readers see (forward) still-pending data.
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset, empties the queue
//   bus : rf_wb_queue_if.slave -- request handshake, register-file write
//         port, two lookup ports, occupancy count and refused-request flag
module rf_wb_queue
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_queue_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t [DEPTH-1:0] mem_q;
  logic   [DEPTH-1:0] valid_q, valid_d;
  logic   [PTR_W-1:0] headPtr_q, headPtr_d;
  logic   [PTR_W-1:0] tailPtr_q, tailPtr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               err_q, err_d;

  logic   reqReady;
  logic   notEmpty;
  logic   push;
  logic   pop;
  entry_t headEntry;
  entry_t newEntry;

  // Readiness depends only on the registered occupancy, so a slot freed by
  // this cycle's drain is only offered to upstream in the next cycle.
  assign reqReady  = (count_q < COUNT_W'(DEPTH));
  assign notEmpty  = (count_q != '0);
  assign push      = bus.req_valid && reqReady;
  assign pop       = notEmpty && bus.drain_en;
  assign headEntry = notEmpty ? mem_q[headPtr_q] : '0;
  assign newEntry  = '{regSel: bus.req_reg, data: bus.req_data};

  assign bus.req_ready      = reqReady;
  assign bus.rf_write       = pop;
  assign bus.rf_writeregsel = headEntry.regSel;
  assign bus.rf_writedata   = headEntry.data;
  assign bus.count          = count_q;
  assign bus.err            = err_q;

  // Next-state for the pointers, occupancy, valid bits and the refused
  // request flag. Push and pop never touch the same slot because a push
  // needs a free slot and a pop needs an occupied one, and the two only
  // coincide on the same index when the queue is empty or full.
  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    valid_d   = valid_q;
    err_d     = bus.req_valid && !reqReady;
    if (pop) begin
      valid_d[headPtr_q] = 1'b0;
      headPtr_d          = headPtr_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[tailPtr_q] = 1'b1;
      tailPtr_d          = tailPtr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset empties the queue immediately so no
  // pending write survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Entry storage needs no reset: a slot's contents are only ever observed
  // while its valid bit is set, and the valid bit is set by the same push
  // that writes it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tailPtr_q] <= newEntry;
    end
  end

  rf_wb_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) uMatch1 (
    .entries_i (mem_q),
    .valid_i   (valid_q),
    .head_i    (headPtr_q),
    .sel_i     (bus.lookup1sel),
    .hit_o     (bus.hit1),
    .data_o    (bus.hit1data)
  );

  rf_wb_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) uMatch2 (
    .entries_i (mem_q),
    .valid_i   (valid_q),
    .head_i    (headPtr_q),
    .sel_i     (bus.lookup2sel),
    .hit_o     (bus.hit2),
    .data_o    (bus.hit2data)
  );

endmodule

// File: doc/rf_wb_queue.md
RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the number of pending write-request entries (power of two, 2..8).
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port req_valid, input, 1: upstream write request present.
REQ-005 Port req_ready, output, 1: queue accepts a request this cycle.
REQ-006 Port req_reg, input, 3: destination register index of the request.
REQ-007 Port req_data, input, 16: data to write.
REQ-008 Port drain_en, input, 1: register-file write port is available this cycle.
REQ-009 Port rf_write, output, 1: write strobe to the register file.
REQ-010 Port rf_writeregsel, output, 3: register index to the register file.
REQ-011 Port rf_writedata, output, 16: write data to the register file.
REQ-012 Ports lookup1sel and lookup2sel, input, 3 each: register indices being read this cycle.
REQ-013 Ports hit1 and hit2, output, 1 each: a pending entry matches the corresponding lookup index.
REQ-014 Ports hit1data and hit2data, output, 16 each: forwarded data for the corresponding lookup.
REQ-015 Port count, output, 4: number of occupied entries (0..DEPTH).
REQ-016 Port err, output, 1: registered indicator that the previous cycle had a request refused.

Function
REQ-017 Storage is an in-order FIFO of DEPTH entries, each holding {reg[2:0], data[15:0]}, managed by head and tail pointers that wrap modulo DEPTH.
REQ-018 req_ready is 1 when count < DEPTH; it is combinational from count only and does not depend on a same-cycle pop.
REQ-019 A push occurs when req_valid && req_ready; the entry is written at tail, tail increments, and count increments.
REQ-020 rf_write = (count != 0) && drain_en, combinationally; rf_writeregsel and rf_writedata always show the head entry, and show 0 when the queue is empty.
REQ-021 A pop occurs when rf_write is 1; head advances at the clock edge.
REQ-022 Minimum latency is 1 cycle: a request accepted at edge N can appear on rf_write in the cycle after edge N.
REQ-023 On a simultaneous push and pop, count is unchanged and both pointers advance.
REQ-024 A full queue with drain_en=1 frees a slot at the edge; req_ready rises in the following cycle.
REQ-025 Lookup searches only stored valid entries, including the head entry being drained this cycle; a same-cycle incoming request is not searched.
REQ-026 When several entries match a lookup index, hitNdata comes from the youngest entry (nearest tail).
REQ-027 When there is no match, hitN=0 and hitNdata=0.
REQ-028 Entries with the same reg are retained and drained in order; entries are never merged.
REQ-029 err is set at each edge to (req_valid && !req_ready) from the prior cycle; it is informational only, and upstream holds the request until accepted.

Reset
REQ-030 rst asserted clears count, head, tail, all valid bits and err immediately, without waiting for a clock edge.
REQ-031 While rst is asserted, rf_write=0, hit1=hit2=0, and req_ready=1 (from count 0); no push takes effect.
REQ-032 Reset asserted mid-drain discards all pending entries; no partial write is re-issued after reset.

Structure
REQ-033 Package rf_wb_pkg holds REG_W=3, DATA_W=16, the default DEPTH, and the entry struct {reg, data}.
REQ-034 A single sub-module, rf_wb_match, implements the youngest-match priority search; it is instantiated once per lookup port.
REQ-035 The block is placed between the writeback source and the register-file write port; its outputs connect directly to that port's write, writeregsel and writedata inputs.

Verification
REQ-036 Reset, then push {r3, 0xBEEF} with drain_en=1: rf_write=1 with sel=3 and data=0xBEEF exactly one cycle later, then count=0.
REQ-037 drain_en=0, push 5 requests with DEPTH=4: req_ready=0 after the 4th, err=1 the cycle after the refused 5th, and count=4.
REQ-038 Push {r2, 0x1111} then {r2, 0x2222} with drain_en=0 and lookup1sel=2: hit1=1 and hit1data=0x2222; lookup2sel=5 gives hit2=0 and hit2data=0.
REQ-039 Full queue, drain_en=1, and req_valid held with new data: one pop and one push per cycle after the first freed slot, rf_write order matches push order, and tail wraps correctly.
REQ-040 Three entries pending, assert rst between clock edges: rf_write=0 and count=0 immediately; after release, no stale write appears.
